// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, immediate generation, 32x32 register file and ID/EX register.
// Optional macro WB_BYPASS_EN enables write-first forwarding from writeback into the register reads.
module decode_cycle (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        stall,
  input  logic        flush,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  output logic [4:0]  Rs1D,
  output logic [4:0]  Rs2D,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE,
  output logic [2:0]  Funct3E,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        BranchE,
  output logic        JumpE,
  output logic        ALUSrcAE,
  output logic        ALUSrcBE,
  output logic [1:0]  ResultSrcE,
  output logic [3:0]  ALUControlE,
  output logic        IllegalE
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_SLL   = 4'b0010;
  localparam logic [3:0] ALU_SLT   = 4'b0011;
  localparam logic [3:0] ALU_SLTU  = 4'b0100;
  localparam logic [3:0] ALU_XOR   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_OR    = 4'b1000;
  localparam logic [3:0] ALU_AND   = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  // funct7[5] selects SUB only for register-register ops; for shifts it selects SRA/SRAI
  function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic f7b5, input logic is_r);
    case (f3)
      3'b000:  alu_fn = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_fn = ALU_SLL;
      3'b010:  alu_fn = ALU_SLT;
      3'b011:  alu_fn = ALU_SLTU;
      3'b100:  alu_fn = ALU_XOR;
      3'b101:  alu_fn = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_fn = ALU_OR;
      default: alu_fn = ALU_AND;
    endcase
  endfunction

  function automatic logic signed [31:0] imm_i(input logic [31:0] ins);
    imm_i = {{20{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic signed [31:0] imm_s(input logic [31:0] ins);
    imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic signed [31:0] imm_b(input logic [31:0] ins);
    imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic signed [31:0] imm_u(input logic [31:0] ins);
    imm_u = {ins[31:12], 12'b0};
  endfunction

  function automatic logic signed [31:0] imm_j(input logic [31:0] ins);
    imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  logic               reg_write_p0, mem_write_p0, branch_p0, jump_p0;
  logic               alu_src_a_p0, alu_src_b_p0, illegal_p0;
  logic [1:0]         result_src_p0;
  logic [3:0]         alu_ctrl_p0;
  logic signed [31:0] imm_p0;
  logic [31:0]        rd1_p0, rd2_p0;
  logic [31:0]        rf [32];

  assign Rs1D = InstrD[19:15];
  assign Rs2D = InstrD[24:20];

  always_comb begin
    reg_write_p0  = 1'b0;
    mem_write_p0  = 1'b0;
    branch_p0     = 1'b0;
    jump_p0       = 1'b0;
    alu_src_a_p0  = 1'b0;
    alu_src_b_p0  = 1'b0;
    result_src_p0 = 2'b00;
    alu_ctrl_p0   = ALU_ADD;
    illegal_p0    = 1'b0;
    imm_p0        = '0;
    case (InstrD[6:0])
      OP_R: begin
        reg_write_p0 = 1'b1;
        alu_ctrl_p0  = alu_fn(InstrD[14:12], InstrD[30], 1'b1);
      end
      OP_I: begin
        reg_write_p0 = 1'b1;
        alu_src_b_p0 = 1'b1;
        alu_ctrl_p0  = alu_fn(InstrD[14:12], InstrD[30], 1'b0);
        imm_p0       = imm_i(InstrD);
      end
      OP_LOAD: begin
        reg_write_p0  = 1'b1;
        alu_src_b_p0  = 1'b1;
        result_src_p0 = 2'b01;
        imm_p0        = imm_i(InstrD);
      end
      OP_STORE: begin
        mem_write_p0 = 1'b1;
        alu_src_b_p0 = 1'b1;
        imm_p0       = imm_s(InstrD);
      end
      OP_BRANCH: begin
        branch_p0    = 1'b1;
        alu_src_a_p0 = 1'b1;
        alu_src_b_p0 = 1'b1;
        imm_p0       = imm_b(InstrD);
      end
      OP_JAL: begin
        reg_write_p0  = 1'b1;
        jump_p0       = 1'b1;
        alu_src_a_p0  = 1'b1;
        alu_src_b_p0  = 1'b1;
        result_src_p0 = 2'b10;
        imm_p0        = imm_j(InstrD);
      end
      OP_JALR: begin
        reg_write_p0  = 1'b1;
        jump_p0       = 1'b1;
        alu_src_b_p0  = 1'b1;
        result_src_p0 = 2'b10;
        imm_p0        = imm_i(InstrD);
      end
      OP_LUI: begin
        reg_write_p0 = 1'b1;
        alu_src_b_p0 = 1'b1;
        alu_ctrl_p0  = ALU_PASSB;
        imm_p0       = imm_u(InstrD);
      end
      OP_AUIPC: begin
        reg_write_p0 = 1'b1;
        alu_src_a_p0 = 1'b1;
        alu_src_b_p0 = 1'b1;
        imm_p0       = imm_u(InstrD);
      end
      default: illegal_p0 = 1'b1;
    endcase
  end

  // Register file: x0 is never written, so its entry stays at the reset value of zero
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (RegWriteW && (RdW != 5'd0)) begin
      rf[RdW] <= ResultW;
    end
  end

`ifdef WB_BYPASS_EN
  assign rd1_p0 = (Rs1D == 5'd0) ? '0 : (RegWriteW && (RdW == Rs1D)) ? ResultW : rf[Rs1D];
  assign rd2_p0 = (Rs2D == 5'd0) ? '0 : (RegWriteW && (RdW == Rs2D)) ? ResultW : rf[Rs2D];
`else
  assign rd1_p0 = (Rs1D == 5'd0) ? '0 : rf[Rs1D];
  assign rd2_p0 = (Rs2D == 5'd0) ? '0 : rf[Rs2D];
`endif

  // ID/EX boundary: flush inserts an all-zero bubble and takes priority over stall
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset || flush) begin
      RD1E <= '0;  RD2E <= '0;  ImmExtE <= '0;  PCE <= '0;  PCPlus4E <= '0;
      Rs1E <= '0;  Rs2E <= '0;  RdE <= '0;  Funct3E <= '0;
      RegWriteE <= 1'b0;  MemWriteE <= 1'b0;  BranchE <= 1'b0;  JumpE <= 1'b0;
      ALUSrcAE <= 1'b0;  ALUSrcBE <= 1'b0;  ResultSrcE <= 2'b00;
      ALUControlE <= ALU_ADD;  IllegalE <= 1'b0;
    end else if (!stall) begin
      RD1E <= rd1_p0;  RD2E <= rd2_p0;  ImmExtE <= imm_p0;  PCE <= PCD;  PCPlus4E <= PCPlus4D;
      Rs1E <= Rs1D;  Rs2E <= Rs2D;  RdE <= InstrD[11:7];  Funct3E <= InstrD[14:12];
      RegWriteE <= reg_write_p0;  MemWriteE <= mem_write_p0;  BranchE <= branch_p0;
      JumpE <= jump_p0;  ALUSrcAE <= alu_src_a_p0;  ALUSrcBE <= alu_src_b_p0;
      ResultSrcE <= result_src_p0;  ALUControlE <= alu_ctrl_p0;  IllegalE <= illegal_p0;
    end
  end

endmodule

// File: tb/tb_decode_cycle.sv
// Scoreboard bench for decode_cycle: expected ID/EX contents are queued at drive time and
// compared one cycle later; a small register-file model supplies the expected read data.
module tb_decode_cycle;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        stall, flush, RegWriteW;
  logic [4:0]  RdW;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [2:0]  Funct3E;
  logic        RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcAE, ALUSrcBE, IllegalE;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUControlE;

  decode_cycle dut (
    .i_clk(i_clk), .i_reset(i_reset), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .stall(stall), .flush(flush), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .Funct3E(Funct3E),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE),
    .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .IllegalE(IllegalE)
  );

  always #5 i_clk = ~i_clk;

  // control word: {RegWrite, MemWrite, Branch, Jump, ALUSrcA, ALUSrcB, ResultSrc[1:0], ALUControl[3:0], Illegal}
  localparam logic [12:0] C_RADD  = 13'b1_0_0_0_0_0_00_0000_0;
  localparam logic [12:0] C_RSUB  = 13'b1_0_0_0_0_0_00_0001_0;
  localparam logic [12:0] C_IADD  = 13'b1_0_0_0_0_1_00_0000_0;
  localparam logic [12:0] C_ISRA  = 13'b1_0_0_0_0_1_00_0111_0;
  localparam logic [12:0] C_LOAD  = 13'b1_0_0_0_0_1_01_0000_0;
  localparam logic [12:0] C_STORE = 13'b0_1_0_0_0_1_00_0000_0;
  localparam logic [12:0] C_BR    = 13'b0_0_1_0_1_1_00_0000_0;
  localparam logic [12:0] C_JAL   = 13'b1_0_0_1_1_1_10_0000_0;
  localparam logic [12:0] C_JALR  = 13'b1_0_0_1_0_1_10_0000_0;
  localparam logic [12:0] C_LUI   = 13'b1_0_0_0_0_1_00_1010_0;
  localparam logic [12:0] C_AUI   = 13'b1_0_0_0_1_1_00_0000_0;
  localparam logic [12:0] C_ILL   = 13'b0_0_0_0_0_0_00_0000_1;

  typedef struct packed {
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [12:0] ctl;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        last_e;
  logic [31:0] rf_m [32];
  logic [31:0] pc_cnt;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    e = sb_q.pop_front();
    chk({tag, ".rd1"}, RD1E, e.rd1);
    chk({tag, ".rd2"}, RD2E, e.rd2);
    chk({tag, ".imm"}, ImmExtE, e.imm);
    chk({tag, ".pc"}, PCE, e.pc);
    chk({tag, ".pc4"}, PCPlus4E, e.pc4);
    chk({tag, ".ctl"},
        {19'b0, RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcAE, ALUSrcBE, ResultSrcE, ALUControlE, IllegalE},
        {19'b0, e.ctl});
    chk({tag, ".idx"}, {14'b0, Rs1E, Rs2E, RdE, Funct3E}, {14'b0, e.rs1, e.rs2, e.rd, e.f3});
  endtask

  function automatic logic [31:0] rd_m(input logic [4:0] a, input logic we, input logic [4:0] wrd,
                                       input logic [31:0] wres);
    if (a == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
    if (we && (wrd == a)) return wres;
`endif
    return rf_m[a];
  endfunction

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  task automatic step(input string tag, input logic [31:0] instr, input logic [12:0] ctl,
                      input logic [31:0] imm, input logic st, input logic fl, input logic we,
                      input logic [4:0] wrd, input logic [31:0] wres);
    exp_t e;
    @(negedge i_clk);
    i_reset = 1'b1;  InstrD = instr;  PCD = pc_cnt;  PCPlus4D = pc_cnt + 32'd4;
    stall = st;  flush = fl;  RegWriteW = we;  RdW = wrd;  ResultW = wres;
    if (fl) e = '0;
    else if (st) e = last_e;
    else begin
      e.rd1 = rd_m(instr[19:15], we, wrd, wres);
      e.rd2 = rd_m(instr[24:20], we, wrd, wres);
      e.imm = imm;  e.pc = pc_cnt;  e.pc4 = pc_cnt + 32'd4;  e.ctl = ctl;
      e.rs1 = instr[19:15];  e.rs2 = instr[24:20];  e.rd = instr[11:7];  e.f3 = instr[14:12];
    end
    last_e = e;
    sb_q.push_back(e);
    #1;
    chk({tag, ".rs1d"}, {27'b0, Rs1D}, {27'b0, instr[19:15]});
    chk({tag, ".rs2d"}, {27'b0, Rs2D}, {27'b0, instr[24:20]});
    @(posedge i_clk);
    if (we && (wrd != 5'd0)) rf_m[wrd] = wres;
    #1;
    pop_cmp(tag);
    pc_cnt = pc_cnt + 32'd4;
  endtask

  task automatic ex(input string tag, input logic [31:0] instr, input logic [12:0] ctl, input logic [31:0] imm);
    step(tag, instr, ctl, imm, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) rf_m[i] = 32'h0;
    last_e = '0;
  endtask

  task automatic rst_cycle(input string tag);
    @(negedge i_clk);
    i_reset = 1'b0;  InstrD = $urandom;  PCD = $urandom;  PCPlus4D = $urandom;
    stall = 1'($urandom);  flush = 1'($urandom);  RegWriteW = 1'b1;
    RdW = 5'($urandom_range(1, 31));  ResultW = $urandom;
    clear_model();
    sb_q.push_back('0);
    @(posedge i_clk);
    #1;
    pop_cmp(tag);
  endtask

  initial begin
    exp_t z;
    i_reset = 1'b1;  InstrD = 32'h13;  PCD = '0;  PCPlus4D = '0;  stall = 1'b0;  flush = 1'b0;
    RegWriteW = 1'b0;  RdW = '0;  ResultW = '0;  pc_cnt = 32'h0000_1000;
    clear_model();
    #1 i_reset = 1'b0;
    for (int i = 0; i < 3; i++) rst_cycle("reset");

    for (int i = 1; i < 32; i++) ex("rd_zero", rtype(7'b0, 5'(i), 5'(i), 3'b000, 5'd0), C_RADD, 32'h0);

    step("wr_x5", 32'h0000_0013, C_IADD, 32'h0, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    ex("add_x6", 32'h0052_8333, C_RADD, 32'h0);
    step("haz_x7", rtype(7'b0, 5'd7, 5'd7, 3'b000, 5'd8), C_RADD, 32'h0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h1234_5678);
    ex("reread_x7", rtype(7'b0, 5'd7, 5'd7, 3'b000, 5'd8), C_RADD, 32'h0);
    step("wr_x0", 32'h0000_0013, C_IADD, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    ex("add_x0", 32'h0000_0033, C_RADD, 32'h0);

    ex("beq", 32'hFE00_0EE3, C_BR, 32'hFFFF_FFFC);
    ex("jal", 32'h8000_00EF, C_JAL, 32'hFFF0_0000);
    ex("sub", rtype(7'b0100000, 5'd7, 5'd5, 3'b000, 5'd9), C_RSUB, 32'h0);
    ex("srai", itype(12'h403, 5'd5, 3'b101, 5'd10, 7'b0010011), C_ISRA, 32'h0000_0403);
    ex("addi_m1", itype(12'hFFF, 5'd5, 3'b000, 5'd11, 7'b0010011), C_IADD, 32'hFFFF_FFFF);
    ex("lw", itype(12'h008, 5'd5, 3'b010, 5'd12, 7'b0000011), C_LOAD, 32'h0000_0008);
    ex("sw", {7'h7F, 5'd7, 5'd5, 3'b010, 5'b11100, 7'b0100011}, C_STORE, 32'hFFFF_FFFC);
    ex("lui", {20'hABCDE, 5'd13, 7'b0110111}, C_LUI, 32'hABCD_E000);
    ex("auipc", {20'h00001, 5'd14, 7'b0010111}, C_AUI, 32'h0000_1000);
    ex("jalr", itype(12'h004, 5'd5, 3'b000, 5'd1, 7'b1100111), C_JALR, 32'h0000_0004);
    ex("illegal", 32'h0000_007F, C_ILL, 32'h0);

    ex("load_s", rtype(7'b0100000, 5'd7, 5'd5, 3'b000, 5'd9), C_RSUB, 32'h0);
    step("stall1", $urandom, 13'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    step("stall2", $urandom, 13'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd20, 32'hCAFE_F00D);
    step("stall3", $urandom, 13'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    ex("rd_x20", rtype(7'b0, 5'd20, 5'd20, 3'b000, 5'd0), C_RADD, 32'h0);
    step("flush_stall", $urandom, 13'h0, 32'h0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
    ex("load_f", itype(12'h008, 5'd5, 3'b010, 5'd12, 7'b0000011), C_LOAD, 32'h0000_0008);
    step("flush", $urandom, 13'h0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);

    ex("pre_rst", itype(12'h008, 5'd5, 3'b010, 5'd12, 7'b0000011), C_LOAD, 32'h0000_0008);
    @(negedge i_clk);
    stall = 1'b1;  flush = 1'b0;  InstrD = $urandom;
    #2 i_reset = 1'b0;
    clear_model();
    z = '0;
    sb_q.push_back(z);
    #1 pop_cmp("async_rst");
    rst_cycle("rst_hold");
    ex("after_rst", rtype(7'b0, 5'd7, 5'd5, 3'b000, 5'd6), C_RADD, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_cycle.md
# decode_cycle

Second stage of the five-stage RV32I pipeline. It takes the IF/ID outputs (`InstrD`, `PCD`, `PCPlus4D`), decodes control, generates the immediate and reads the 32×32 register file. It registers everything into the ID/EX pipeline register and owns the register-file write port driven from writeback. It honours `stall` (hold) and `flush` (bubble) from the hazard unit, with the same priority scheme as the fetch stage.

## Interface
Parameters: none (RV32I, XLEN fixed at 32).

- `i_clk` in 1: sole clock, rising edge.
- `i_reset` in 1: asynchronous, active-low reset.
- `InstrD` in 32: instruction from IF/ID (NOP = `0x00000013`).
- `PCD` in 32: PC of `InstrD`.
- `PCPlus4D` in 32: PC+4 of `InstrD`.
- `stall` in 1: hold the ID/EX register.
- `flush` in 1: load a bubble into ID/EX.
- `RegWriteW` in 1: writeback enable.
- `RdW` in 5: writeback destination.
- `ResultW` in 32: writeback data.
- `Rs1D`, `Rs2D` out 5 each: combinational `InstrD[19:15]` / `InstrD[24:20]`, for the hazard unit.
- `RD1E`, `RD2E` out 32: registered rs1/rs2 data.
- `ImmExtE` out 32: registered sign-extended immediate.
- `PCE`, `PCPlus4E` out 32: registered copies of `PCD` and `PCPlus4D`.
- `Rs1E`, `Rs2E`, `RdE` out 5: registered register indices.
- `Funct3E` out 3: registered `InstrD[14:12]`, used by the branch comparator.
- `RegWriteE`, `MemWriteE`, `BranchE`, `JumpE`, `ALUSrcAE`, `ALUSrcBE` out 1 each.
- `ResultSrcE` out 2: 00 = ALU, 01 = memory, 10 = PC+4.
- `ALUControlE` out 4: ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001, PASSB 1010.
- `IllegalE` out 1: registered unknown-opcode flag.

## Operation
**Decode by opcode:**
- R-type 0110011: ALU op from funct3 and funct7[5]; `RegWrite`=1.
- I-ALU 0010011: `ALUSrcB`=1; funct7[5] is honoured only for SRAI; SUB is never produced.
- LOAD 0000011: ADD, `ALUSrcB`=1, `ResultSrc`=01, `RegWrite`=1.
- STORE 0100011: ADD, `ALUSrcB`=1, `MemWrite`=1.
- BRANCH 1100011: ADD, `ALUSrcA`=1, `ALUSrcB`=1, `Branch`=1.
- JAL 1101111: ADD, `ALUSrcA`=1, `ALUSrcB`=1, `Jump`=1, `ResultSrc`=10, `RegWrite`=1.
- JALR 1100111: ADD, `ALUSrcB`=1, `Jump`=1, `ResultSrc`=10, `RegWrite`=1.
- LUI 0110111: PASSB, `ALUSrcB`=1, `RegWrite`=1.
- AUIPC 0010111: ADD, `ALUSrcA`=1, `ALUSrcB`=1, `RegWrite`=1.
- Any other opcode: all control 0, `IllegalE`=1.

**Immediate:** I, S, B, U and J formats per the RV32I encoding, sign bit `InstrD[31]`. B and J immediates have bit 0 = 0. For R-type the immediate is 0.

**Register file:**
- x0 reads 0 always; writes to x0 are discarded.
- Write on the rising edge when `RegWriteW`=1 and `RdW`≠0.
- Writes are independent of `stall` and `flush`.
- Reads are combinational and land in ID/EX.

**ID/EX register update priority:** reset > flush > stall > load.
- flush: every E output becomes 0, except `ALUControlE`=0000. The result is a bubble with no side effects.
- stall: every E output holds its value.
- flush and stall together: flush wins.

## Timing
- Reset (asynchronous, `i_reset`=0): all E outputs 0, all 32 registers 0, `IllegalE`=0. Release is synchronous to the next edge.
- Latency: 1 cycle. `InstrD` present at edge N appears decoded on the E outputs after edge N.
- `Rs1D` and `Rs2D` have zero latency (combinational).
- Reset mid-stall or mid-flush clears immediately; stall and flush are ignored while reset is low.
- A register written at edge N is visible in `RD*E` no earlier than the instruction loaded at edge N+1, unless `WB_BYPASS_EN` is defined.

## Configuration
- `WB_BYPASS_EN` defined: write-first internal forwarding. If `RegWriteW`=1, `RdW`≠0 and `RdW` equals rs1 or rs2, that read returns `ResultW` in the same cycle.
- `WB_BYPASS_EN` undefined: reads return the pre-write array value. The hazard unit must cover the writeback-to-decode distance with a stall or forwarding.

## Test plan
- Reset: hold `i_reset`=0 with random inputs → all E outputs 0; after release, reading x1..x31 gives 0.
- Write then read: WB writes x5=`0xDEADBEEF`; next cycle `InstrD`=`0x00528333` (add x6,x5,x5) → `RD1E`=`RD2E`=`0xDEADBEEF`, `ALUControlE`=0000, `RdE`=6, `RegWriteE`=1.
- Same-cycle hazard: WB writes x7=`0x12345678` in the same cycle `InstrD` reads x7 → `RD1E`=`0x12345678` with `WB_BYPASS_EN`; the old value without it.
- x0 protection: WB writes x0=`0xFFFFFFFF`; then `InstrD`=`0x00000033` (add x0,x0,x0) → `RD1E`=`RD2E`=0.
- Immediates: `InstrD`=`0xFE000EE3` (beq x0,x0,-4) → `ImmExtE`=`0xFFFFFFFC`, `BranchE`=1, `ALUSrcAE`=1. `InstrD`=`0x800000EF` (jal) → `ImmExtE`=`0xFFF00000`, `JumpE`=1, `ResultSrcE`=10.
- Stall and flush: load an instruction, assert `stall` for 3 cycles → E outputs unchanged. Assert `flush` and `stall` together → `RegWriteE`=`MemWriteE`=`BranchE`=`JumpE`=0 next cycle. Opcode `0x7F` → `IllegalE`=1 with all control 0.
